// File: rtl/mux_rr_n.sv
// mux_rr_n: N-channel round-robin time-multiplexing mux with valid/ready
// flow control and a registered output stage.
//
// Build option: MUX_SKIP_IDLE_EN
//   undefined - strict TDM, every channel owns one output slot in turn
//   defined   - skip idle channels (work-conserving round-robin)
//
// ptr_q is the only sequencing state, so there is no separate FSM.
// ptr_q | meaning
//   k   | channel k is the next one offered a slot (0 <= k < NCH)

module mux_rr_n #(
    parameter int WIDTH = 4,
    parameter int NCH   = 2,
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic [NCH*WIDTH-1:0] data_in,
    input  logic [NCH-1:0]       valid_in,
    output logic [NCH-1:0]       pop,
    output logic [WIDTH-1:0]     data_out,
    output logic                 valid_out,
    output logic [CW-1:0]        chan_out,
    input  logic                 ready_in
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [CW-1:0]    chan_q, chan_d;
    logic [CW-1:0]    ptr_q, ptr_d;

    logic             load_c;
    logic             found_c;
    logic [CW-1:0]    sel_c;
    logic [WIDTH-1:0] chan_word [NCH];

    // Next channel after p; explicit wrap because NCH need not be a power of two.
    function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] p);
        if (p == CW'(NCH - 1)) begin
            return '0;
        end
        return p + CW'(1);
    endfunction

    // Channel reached after stepping i places from p, modulo NCH.
    function automatic logic [CW-1:0] step_from(input logic [CW-1:0] p, input int i);
        int s;
        s = int'(p) + i;
        if (s >= NCH) begin
            s = s - NCH;
        end
        return CW'(s);
    endfunction

    // Split the flat input bus into per-channel words.
    for (genvar g = 0; g < NCH; g++) begin : g_split
        assign chan_word[g] = data_in[g*WIDTH +: WIDTH];
    end

    // Channel selection: strict slot order, or first valid channel from ptr onward.
    always_comb begin
        found_c = 1'b0;
        sel_c   = ptr_q;
`ifdef MUX_SKIP_IDLE_EN
        for (int i = 0; i < NCH; i++) begin
            if (!found_c && valid_in[step_from(ptr_q, i)]) begin
                found_c = 1'b1;
                sel_c   = step_from(ptr_q, i);
            end
        end
`else
        // Every slot is taken by ptr_q whether or not that channel has data.
        found_c = 1'b1;
`endif
    end

    // Output-register next state and the combinational dequeue strobes.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        chan_d  = chan_q;
        ptr_d   = ptr_q;
        pop     = '0;
        // Slot is empty or its word leaves this cycle, so a new one may enter.
        load_c  = !valid_q || ready_in;

        if (load_c) begin
            if (found_c) begin
                data_d  = chan_word[sel_c];
                chan_d  = sel_c;
                ptr_d   = wrap_inc(sel_c);
`ifdef MUX_SKIP_IDLE_EN
                valid_d = 1'b1;
`else
                valid_d = valid_in[sel_c];
`endif
            end else begin
                // Nothing to send: drain the slot but keep data, channel and ptr.
                valid_d = 1'b0;
            end

            // Gated by reset so a producer never dequeues a word that is then dropped.
            if (reset_L && found_c && valid_in[sel_c]) begin
                pop[sel_c] = 1'b1;
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            chan_q  <= '0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign chan_out  = chan_q;

    // Structural invariants: pointer in range, at most one dequeue, stall holds.
    a_ptr_range : assert property (@(posedge clk) disable iff (!reset_L)
        int'(ptr_q) < NCH);
    a_pop_onehot : assert property (@(posedge clk) disable iff (!reset_L)
        $onehot0(pop));
    a_stall_hold : assert property (@(posedge clk) disable iff (!reset_L)
        (valid_q && !ready_in) |=> ($stable(data_q) && $stable(chan_q) && $stable(ptr_q) && valid_q));

endmodule

// File: tb/tb_mux_rr_n.sv
// Bench for mux_rr_n: NCH=2 and NCH=3 instances in every build, plus an NCH=4
// instance when MUX_SKIP_IDLE_EN is defined.

module tb_mux_rr_n;

    typedef struct {
        int         id;
        logic [3:0] vin;
        logic       rdy;
        logic [3:0] pop;
        logic       vout;
        int         chan;
        logic [3:0] data;
        int         ptr;
    } vec_t;

    typedef struct {
        int         id;
        int         row;
        logic       vout;
        int         chan;
        logic [3:0] data;
        int         ptr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // NCH=2 instance
    logic       rst2 = 1'b0;
    logic [7:0] d2   = {4'h5, 4'hA};
    logic [1:0] v2   = 2'b00;
    logic       r2   = 1'b1;
    logic [1:0] p2;
    logic [3:0] do2;
    logic       vo2;
    logic       ch2;

    mux_rr_n #(.WIDTH(4), .NCH(2)) u2 (
        .clk(clk), .reset_L(rst2), .data_in(d2), .valid_in(v2), .pop(p2),
        .data_out(do2), .valid_out(vo2), .chan_out(ch2), .ready_in(r2)
    );

    // NCH=3 instance
    logic        rst3 = 1'b0;
    logic [11:0] d3   = {4'h3, 4'h2, 4'h1};
    logic [2:0]  v3   = 3'b000;
    logic        r3   = 1'b1;
    logic [2:0]  p3;
    logic [3:0]  do3;
    logic        vo3;
    logic [1:0]  ch3;

    mux_rr_n #(.WIDTH(4), .NCH(3)) u3 (
        .clk(clk), .reset_L(rst3), .data_in(d3), .valid_in(v3), .pop(p3),
        .data_out(do3), .valid_out(vo3), .chan_out(ch3), .ready_in(r3)
    );

`ifdef MUX_SKIP_IDLE_EN
    // NCH=4 instance
    logic        rst4 = 1'b0;
    logic [15:0] d4   = {4'hB, 4'hA, 4'h9, 4'h8};
    logic [3:0]  v4   = 4'b0000;
    logic        r4   = 1'b1;
    logic [3:0]  p4;
    logic [3:0]  do4;
    logic        vo4;
    logic [1:0]  ch4;

    mux_rr_n #(.WIDTH(4), .NCH(4)) u4 (
        .clk(clk), .reset_L(rst4), .data_in(d4), .valid_in(v4), .pop(p4),
        .data_out(do4), .valid_out(vo4), .chan_out(ch4), .ready_in(r4)
    );
`endif

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(int id, logic [3:0] vin, logic rdy, logic [3:0] pop,
                                logic vout, int chan, logic [3:0] data, int ptr);
        vec_t v;
        v.id = id; v.vin = vin; v.rdy = rdy; v.pop = pop;
        v.vout = vout; v.chan = chan; v.data = data; v.ptr = ptr;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input int id, input logic [3:0] vin, input logic rdy);
        case (id)
            0: begin rst2 = 1'b1; v2 = vin[1:0]; r2 = rdy; end
            1: begin rst3 = 1'b1; v3 = vin[2:0]; r3 = rdy; end
`ifdef MUX_SKIP_IDLE_EN
            2: begin rst4 = 1'b1; v4 = vin; r4 = rdy; end
`endif
            default: ;
        endcase
    endtask

    function automatic logic [31:0] get_pop(input int id);
        case (id)
            0: return 32'(p2);
            1: return 32'(p3);
`ifdef MUX_SKIP_IDLE_EN
            2: return 32'(p4);
`endif
            default: return 32'hdead;
        endcase
    endfunction

    function automatic logic [31:0] get_vout(input int id);
        case (id)
            0: return 32'(vo2);
            1: return 32'(vo3);
`ifdef MUX_SKIP_IDLE_EN
            2: return 32'(vo4);
`endif
            default: return 32'hdead;
        endcase
    endfunction

    function automatic logic [31:0] get_chan(input int id);
        case (id)
            0: return 32'(ch2);
            1: return 32'(ch3);
`ifdef MUX_SKIP_IDLE_EN
            2: return 32'(ch4);
`endif
            default: return 32'hdead;
        endcase
    endfunction

    function automatic logic [31:0] get_data(input int id);
        case (id)
            0: return 32'(do2);
            1: return 32'(do3);
`ifdef MUX_SKIP_IDLE_EN
            2: return 32'(do4);
`endif
            default: return 32'hdead;
        endcase
    endfunction

    function automatic logic [31:0] get_ptr(input int id);
        case (id)
            0: return 32'(u2.ptr_q);
            1: return 32'(u3.ptr_q);
`ifdef MUX_SKIP_IDLE_EN
            2: return 32'(u4.ptr_q);
`endif
            default: return 32'hdead;
        endcase
    endfunction

    initial begin
        exp_t e;

        // T1: both channels valid, alternating A,5
        vecs.push_back(mk(0, 4'b0011, 1'b1, 4'b0001, 1'b1, 0, 4'hA, 1));
        vecs.push_back(mk(0, 4'b0011, 1'b1, 4'b0010, 1'b1, 1, 4'h5, 0));
        vecs.push_back(mk(0, 4'b0011, 1'b1, 4'b0001, 1'b1, 0, 4'hA, 1));
        vecs.push_back(mk(0, 4'b0011, 1'b1, 4'b0010, 1'b1, 1, 4'h5, 0));
        // T4: three stall cycles with valid_in wandering, then resume on ch0
        vecs.push_back(mk(0, 4'b0011, 1'b0, 4'b0000, 1'b1, 1, 4'h5, 0));
        vecs.push_back(mk(0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1, 4'h5, 0));
        vecs.push_back(mk(0, 4'b0010, 1'b0, 4'b0000, 1'b1, 1, 4'h5, 0));
        vecs.push_back(mk(0, 4'b0011, 1'b1, 4'b0001, 1'b1, 0, 4'hA, 1));
`ifndef MUX_SKIP_IDLE_EN
        // T3: ch1 idle still owns its slot; empty slot loads even without ready
        vecs.push_back(mk(0, 4'b0001, 1'b1, 4'b0000, 1'b0, 1, 4'h5, 0));
        vecs.push_back(mk(0, 4'b0001, 1'b1, 4'b0001, 1'b1, 0, 4'hA, 1));
        vecs.push_back(mk(0, 4'b0001, 1'b1, 4'b0000, 1'b0, 1, 4'h5, 0));
        vecs.push_back(mk(0, 4'b0001, 1'b0, 4'b0001, 1'b1, 0, 4'hA, 1));
        vecs.push_back(mk(0, 4'b0001, 1'b0, 4'b0000, 1'b1, 0, 4'hA, 1));
        vecs.push_back(mk(0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1, 4'h5, 0));
`endif
        // T2: NCH=3 wraps 2 -> 0
        vecs.push_back(mk(1, 4'b0111, 1'b1, 4'b0001, 1'b1, 0, 4'h1, 1));
        vecs.push_back(mk(1, 4'b0111, 1'b1, 4'b0010, 1'b1, 1, 4'h2, 2));
        vecs.push_back(mk(1, 4'b0111, 1'b1, 4'b0100, 1'b1, 2, 4'h3, 0));
        vecs.push_back(mk(1, 4'b0111, 1'b1, 4'b0001, 1'b1, 0, 4'h1, 1));
        vecs.push_back(mk(1, 4'b0111, 1'b1, 4'b0010, 1'b1, 1, 4'h2, 2));
`ifdef MUX_SKIP_IDLE_EN
        // T5: only ch1/ch3 valid, then all idle, then search wraps from ptr
        vecs.push_back(mk(2, 4'b1010, 1'b1, 4'b0010, 1'b1, 1, 4'h9, 2));
        vecs.push_back(mk(2, 4'b1010, 1'b1, 4'b1000, 1'b1, 3, 4'hB, 0));
        vecs.push_back(mk(2, 4'b1010, 1'b1, 4'b0010, 1'b1, 1, 4'h9, 2));
        vecs.push_back(mk(2, 4'b1010, 1'b1, 4'b1000, 1'b1, 3, 4'hB, 0));
        vecs.push_back(mk(2, 4'b0000, 1'b1, 4'b0000, 1'b0, 3, 4'hB, 0));
        vecs.push_back(mk(2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2, 4'hA, 3));
        vecs.push_back(mk(2, 4'b0001, 1'b1, 4'b0001, 1'b1, 0, 4'h8, 1));
`endif

        // Reset state, with inputs active so pop gating under reset is exercised
        v2 = 2'b11;
        v3 = 3'b111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_data", -1, get_data(0), 0);
        chk("rst_valid", -1, get_vout(0), 0);
        chk("rst_chan", -1, get_chan(0), 0);
        chk("rst_pop", -1, get_pop(0), 0);
        chk("rst_pop3", -1, get_pop(1), 0);
        chk("rst_valid3", -1, get_vout(1), 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].id, vecs[i].vin, vecs[i].rdy);
            #1;
            chk("pop", i, get_pop(vecs[i].id), 32'(vecs[i].pop));
            e.id = vecs[i].id; e.row = i; e.vout = vecs[i].vout;
            e.chan = vecs[i].chan; e.data = vecs[i].data; e.ptr = vecs[i].ptr;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("sb_empty", i, 1, 0);
            end else begin
                e = sb.pop_front();
                chk("valid_out", e.row, get_vout(e.id), 32'(e.vout));
                chk("chan_out", e.row, get_chan(e.id), e.chan);
                chk("data_out", e.row, get_data(e.id), 32'(e.data));
                chk("ptr", e.row, get_ptr(e.id), e.ptr);
            end
        end

        // T6: async reset mid-stream while ptr points at ch1
        @(negedge clk);
        drive(0, 4'b0011, 1'b1);
        for (int k = 0; k < 4 && !(vo2 === 1'b1 && ch2 === 1'b0); k++) begin
            @(posedge clk);
            #1;
        end
        chk("t6_pre", -1, 32'(vo2 === 1'b1 && ch2 === 1'b0), 1);
        #2;
        rst2 = 1'b0;
        #1;
        chk("t6_data", -1, get_data(0), 0);
        chk("t6_valid", -1, get_vout(0), 0);
        chk("t6_chan", -1, get_chan(0), 0);
        chk("t6_pop", -1, get_pop(0), 0);
        #3;
        rst2 = 1'b1;
        #1;
        chk("t6_pop_rel", -1, get_pop(0), 32'h1);
        @(posedge clk);
        #1;
        chk("t6_valid_rel", -1, get_vout(0), 1);
        chk("t6_chan_rel", -1, get_chan(0), 0);
        chk("t6_data_rel", -1, get_data(0), 32'hA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
